// File: rtl/arb_mux_reg_if.sv
// rtl/arb_mux_reg_if.sv - stream bundle between N producers, the selector and one consumer
//
// Purpose: groups the per-channel input streams, the mode controls and the
// registered output stream of arb_mux_reg into one interface.
// Signals:
//   in_data   NUM_IN*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid  NUM_IN             per-channel valid
//   in_ready  NUM_IN             per-channel ready (one-hot or zero)
//   rr_en     1                  0 = fixed select, 1 = round robin
//   sel       SEL_WIDTH          channel index for fixed select
//   out_data  DATA_WIDTH         registered output word
//   out_src   SEL_WIDTH          channel that supplied out_data
//   out_valid 1                  output register holds a word
//   out_ready 1                  consumer accepts the word
// Modports: master = environment side (producers/consumer), slave = selector.

interface arb_mux_reg_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 5
) ();
  localparam int SEL_WIDTH = $clog2(NUM_IN);

  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN-1:0]            in_ready;
  logic                         rr_en;
  logic [SEL_WIDTH-1:0]         sel;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SEL_WIDTH-1:0]         out_src;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, rr_en, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, rr_en, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/arb_mux_reg.sv
// rtl/arb_mux_reg.sv - N-input registered selector, fixed select or round robin
//
// Purpose: picks one valid/ready input stream per cycle (explicit select or
// round-robin) and loads the chosen word into a single output register that
// holds under back-pressure and sustains one word per cycle.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      arb_mux_reg_if.slave (in_data/in_valid/in_ready, rr_en, sel,
//            out_data/out_src/out_valid/out_ready)

module arb_mux_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 5,
  localparam int SEL_WIDTH = $clog2(NUM_IN)
) (
  input  logic          clk,
  input  logic          reset_n,
  arb_mux_reg_if.slave  bus
);

  logic [DATA_WIDTH-1:0] words [NUM_IN];
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  grant;
  logic [SEL_WIDTH-1:0]  ptr_next;
  logic                  grant_vld;
  logic                  load_en;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SEL_WIDTH-1:0]  src_q;
  logic                  valid_q;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign words[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign load_en  = !valid_q || bus.out_ready;
  assign out_xfer = valid_q && bus.out_ready;

  // Grant decision. In fixed mode the grant does not depend on in_valid, so
  // in_ready[sel] follows load_en alone. In round-robin mode the search
  // starts at ptr and wraps; sum needs one extra bit to hold ptr+k before
  // the modulo reduction.
  always_comb begin
    logic [SEL_WIDTH:0]   sum;
    logic [SEL_WIDTH-1:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    sum       = '0;
    idx       = '0;
    if (!bus.rr_en) begin
      if (int'(bus.sel) < NUM_IN) begin
        grant     = bus.sel;
        grant_vld = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        sum = {1'b0, ptr} + (SEL_WIDTH+1)'(k);
        if (sum >= (SEL_WIDTH+1)'(NUM_IN)) begin
          sum = sum - (SEL_WIDTH+1)'(NUM_IN);
        end
        idx = sum[SEL_WIDTH-1:0];
        if (!grant_vld && bus.in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // reset_n gates ready so no producer sees a handshake while held in reset.
  always_comb begin
    bus.in_ready = '0;
    if (grant_vld && load_en && reset_n) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  assign in_xfer  = grant_vld && load_en && bus.in_valid[grant];
  assign ptr_next = (grant == SEL_WIDTH'(NUM_IN - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else begin
      if (in_xfer) begin
        data_q  <= words[grant];
        src_q   <= grant;
        valid_q <= 1'b1;
        if (bus.rr_en) begin
          ptr <= ptr_next;
        end
      end else if (out_xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb/tb_arb_mux_reg.sv - directed self-checking bench for arb_mux_reg

module tb_arb_mux_reg;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_IN     = 5;
  localparam int SEL_WIDTH  = $clog2(NUM_IN);

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  arb_mux_reg_if #(.DATA_WIDTH(DATA_WIDTH), .NUM_IN(NUM_IN)) bus ();

  arb_mux_reg #(.DATA_WIDTH(DATA_WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < NUM_IN; i++) begin
      bus.in_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(32'h1110 * i);
    end
  endtask

  initial begin
    int e;
    int seq [4];

    // Reset with random inputs.
    reset_n = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      bus.in_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
    end
    bus.in_valid  = NUM_IN'($urandom);
    bus.rr_en     = 1'($urandom);
    bus.sel       = SEL_WIDTH'($urandom);
    bus.out_ready = 1'($urandom);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data", 32'(bus.out_data), 32'h0);
    check("rst_src", 32'(bus.out_src), 32'h0);
    check("rst_in_ready2", 32'(bus.in_ready), 32'h0);

    // Round robin, full load: 0,1,2,3,4,0,1 with ptr wrapping 4->0.
    load_table();
    bus.in_valid  = '1;
    bus.rr_en     = 1'b1;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int j = 0; j < 7; j++) begin
      e = j % NUM_IN;
      check("rr_in_ready", 32'(bus.in_ready), 32'(1 << e));
      tick();
      check("rr_src", 32'(bus.out_src), 32'(e));
      check("rr_data", 32'(bus.out_data), 32'h1110 * e);
      check("rr_valid", 32'(bus.out_valid), 32'h1);
    end

    // Fixed select sel=2.
    bus.rr_en = 1'b0;
    bus.sel   = SEL_WIDTH'(2);
    #1;
    for (int j = 0; j < 3; j++) begin
      check("fix_in_ready", 32'(bus.in_ready), 32'h04);
      tick();
      check("fix_src", 32'(bus.out_src), 32'h2);
      check("fix_data", 32'(bus.out_data), 32'h2220);
      check("fix_valid", 32'(bus.out_valid), 32'h1);
    end

    // Illegal select: nothing granted, pending word drains.
    bus.sel = SEL_WIDTH'(5);
    #1;
    check("ill_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    check("ill_valid", 32'(bus.out_valid), 32'h0);
    check("ill_in_ready2", 32'(bus.in_ready), 32'h0);
    tick();
    check("ill_valid2", 32'(bus.out_valid), 32'h0);
    check("ill_data_kept", 32'(bus.out_data), 32'h2220);

    // ptr is still 2; a single transfer from channel 0 moves it to 1.
    bus.rr_en    = 1'b1;
    bus.in_valid = 5'b00001;
    #1;
    check("ptr_in_ready", 32'(bus.in_ready), 32'h01);
    tick();
    check("ptr_src", 32'(bus.out_src), 32'h0);

    // Sparse: channels 1 and 3.
    bus.in_valid = 5'b01010;
    seq = '{1, 3, 1, 3};
    #1;
    for (int j = 0; j < 4; j++) begin
      check("sp_in_ready", 32'(bus.in_ready), 32'(1 << seq[j]));
      tick();
      check("sp_src", 32'(bus.out_src), 32'(seq[j]));
      check("sp_data", 32'(bus.out_data), 32'h1110 * seq[j]);
    end

    // Back-pressure for 3 cycles.
    bus.out_ready = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      check("bp_src", 32'(bus.out_src), 32'h3);
      check("bp_data", 32'(bus.out_data), 32'h3330);
      check("bp_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_rel_in_ready", 32'(bus.in_ready), 32'h02);
    tick();
    check("bp_rel_src", 32'(bus.out_src), 32'h1);
    check("bp_rel_data", 32'(bus.out_data), 32'h1110);

    // Bring ptr to 3 with a word held, then reset between edges.
    bus.in_valid = 5'b00100;
    #1;
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'h04);
    tick();
    check("pre_rst_src", 32'(bus.out_src), 32'h2);
    bus.out_ready = 1'b0;
    bus.in_valid  = 5'b01001;
    #1;
    check("pre_rst_hold", 32'(bus.in_ready), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_data", 32'(bus.out_data), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    #3;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h01);
    tick();
    check("post_rst_src", 32'(bus.out_src), 32'h0);
    check("post_rst_valid", 32'(bus.out_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arb_mux_reg.md
# arb_mux_reg

Parametrised N-input registered selector for the processor datapath. Each input is a valid/ready stream. The block chooses one input per cycle, either by an explicit select or by round-robin arbitration, and places the chosen word in a single output register. It replaces the fixed-width combinational 2/4/5-way selectors wherever a source must be held under back-pressure or several producers share one consumer.

## Interface
Parameters:
- DATA_WIDTH, 16, width of each data word.
- NUM_IN, 5, number of input channels; legal range 2..16.
- SEL_WIDTH, $clog2(NUM_IN), width of select and source-index fields; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit high in any cycle.
- rr_en  input  1  0 = fixed-select mode, 1 = round-robin mode.
- sel  input  SEL_WIDTH  channel index used in fixed-select mode.
- out_data  output  DATA_WIDTH  registered output word.
- out_src  output  SEL_WIDTH  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

## Operation
- Transfer: an input transfer occurs on channel i when in_valid[i] and in_ready[i] are both high at a rising edge. An output transfer occurs when out_valid and out_ready are both high.
- load_en = !out_valid || out_ready. The register can take a new word when it is empty or is being drained in the same cycle.
- Fixed-select mode (rr_en=0):
  - The grant is channel sel when sel < NUM_IN.
  - in_ready[sel] = load_en, independent of in_valid[sel].
  - sel >= NUM_IN grants no channel. All in_ready bits are 0 and nothing loads.
- Round-robin mode (rr_en=1):
  - The search order is ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1, wrapping modulo NUM_IN.
  - The grant is the first channel in that order with in_valid high.
  - in_ready[grant] = load_en. If no channel is valid, all in_ready bits are 0.
- Pointer ptr:
  - SEL_WIDTH-bit register, range 0..NUM_IN-1.
  - Updates only on an input transfer made in round-robin mode: ptr <= (grant+1) mod NUM_IN. Wrap from NUM_IN-1 goes to 0.
  - Holds its value in fixed-select mode and in idle cycles.
- Register update:
  - On an input transfer: out_data <= granted word, out_src <= grant, out_valid <= 1.
  - If an output transfer occurs with no input transfer: out_valid <= 0. out_data and out_src keep their last values.
  - Simultaneous output and input transfer: the new word replaces the old one in the same edge, giving 1 word/cycle throughput.
- Back-pressure: while out_valid=1 and out_ready=0:
  - all in_ready bits are 0;
  - out_data, out_src and out_valid hold stable.
- Mode changes:
  - rr_en and sel are sampled combinationally every cycle. A change takes effect on the next grant decision.
  - A word already in the register is unaffected, and ptr is retained.
- in_ready may depend combinationally on in_valid, rr_en, sel and out_ready. No output depends combinationally on in_data.

## Timing
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is 0 during reset.
- First cycle after release: load_en=1, so a valid granted channel can transfer immediately.
- Latency: 1 cycle. A word transferred at edge k appears on out_data with out_valid=1 after edge k.
- Throughput: 1 word per cycle while out_ready stays high.
- Reset asserted mid-operation: the held word is discarded, out_valid drops immediately without waiting for clk, and ptr returns to 0.

## Test plan
- Reset: hold reset_n=0 with random inputs, then release. Required: out_valid=0, out_data=0x0000, out_src=0. The first round-robin grant with all channels valid is channel 0.
- Fixed select: rr_en=0, sel=2, all valid, in_data[i]=0x1110*i, out_ready=1. Required: in_ready=5'b00100 every cycle. out_data=0x2220 and out_src=2 from the second cycle on.
- Illegal select: rr_en=0, sel=5 with NUM_IN=5, all valid. Required: in_ready=0. After the pending word drains, out_valid=0 and stays 0.
- Round robin, full load: rr_en=1, all valid, out_ready=1. Required: out_src sequence 0,1,2,3,4,0,1, with ptr wrapping 4→0.
- Round robin, sparse with back-pressure: only channels 1 and 3 valid, giving out_src 1,3,1,3. Then drive out_ready=0 for 3 cycles. Required: out_data and out_src frozen, and in_ready=0 throughout. On release, the next grant follows the last-served channel.
- Reset mid-stream: assert reset_n low between edges while out_valid=1 and ptr=3. Required: out_valid=0 immediately. After release, with channels 0 and 3 valid, the first grant is channel 0.
